// File: rtl/cic_iq_decim.sv
// Complex (I/Q) CIC decimator, M=1: per-strobe integrators, comb section time-multiplexed one stage per clock.
// Optional macro CIC_ROUND_EN: round half up with positive saturation, one extra cycle of latency.
module cic_iq_decim #(
    parameter int IN_WIDTH  = 24,
    parameter int OUT_WIDTH = 24,
    parameter int STAGES    = 5,
    parameter int DECIM     = 3
) (
    input  logic                        adc_clk,
    input  logic                        reset_n,
    input  logic                        in_strobe,
    input  logic signed [IN_WIDTH-1:0]  in_data_i,
    input  logic signed [IN_WIDTH-1:0]  in_data_q,
    output logic                        out_strobe,
    output logic signed [OUT_WIDTH-1:0] out_data_i,
    output logic signed [OUT_WIDTH-1:0] out_data_q,
    output logic                        overrun
);
    localparam int GROWTH = $clog2(DECIM ** STAGES);
    localparam int ACCW   = IN_WIDTH + GROWTH;
    localparam int CW     = $clog2(DECIM);
    localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1;

    typedef enum logic [1:0] {IDLE, COMB, RND, OUT} state_t;
    state_t state_reg, state_next;

    logic signed [ACCW-1:0] int_i_reg  [STAGES];
    logic signed [ACCW-1:0] int_q_reg  [STAGES];
    logic signed [ACCW-1:0] int_i_next [STAGES];
    logic signed [ACCW-1:0] int_q_next [STAGES];
    logic signed [ACCW-1:0] dly_i_reg  [STAGES];
    logic signed [ACCW-1:0] dly_q_reg  [STAGES];
    logic signed [ACCW-1:0] comb_i_reg, comb_q_reg;
    logic [CW-1:0]          dec_cnt_reg;
    logic [SW-1:0]          stage_reg;
    logic                   dec_event;
    logic                   out_strobe_reg, overrun_reg;
    logic signed [OUT_WIDTH-1:0] out_i_reg, out_q_reg;

    assign dec_event = in_strobe && (dec_cnt_reg == CW'(DECIM - 1));

    // Each integrator adds the previous stage's pre-update value.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_int
        if (gi == 0) begin : g_first
            assign int_i_next[gi] = int_i_reg[gi] + {{GROWTH{in_data_i[IN_WIDTH-1]}}, in_data_i};
            assign int_q_next[gi] = int_q_reg[gi] + {{GROWTH{in_data_q[IN_WIDTH-1]}}, in_data_q};
        end else begin : g_rest
            assign int_i_next[gi] = int_i_reg[gi] + int_i_reg[gi-1];
            assign int_q_next[gi] = int_q_reg[gi] + int_q_reg[gi-1];
        end
    end

`ifdef CIC_ROUND_EN
    localparam int SH = ACCW - OUT_WIDTH;
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    // Adding half an LSB then truncating equals adding the first discarded bit to the kept bits.
    logic signed [OUT_WIDTH:0]   rnd_i_wide, rnd_q_wide;
    logic signed [OUT_WIDTH-1:0] rnd_i_reg, rnd_q_reg;
    assign rnd_i_wide = {comb_i_reg[ACCW-1], comb_i_reg[ACCW-1 -: OUT_WIDTH]}
                        + (OUT_WIDTH+1)'(comb_i_reg[SH-1]);
    assign rnd_q_wide = {comb_q_reg[ACCW-1], comb_q_reg[ACCW-1 -: OUT_WIDTH]}
                        + (OUT_WIDTH+1)'(comb_q_reg[SH-1]);
`endif

    always_ff @(posedge adc_clk) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (dec_event) state_next = COMB;
            COMB: if (stage_reg == SW'(STAGES - 1)) begin
`ifdef CIC_ROUND_EN
                state_next = RND;
`else
                state_next = OUT;
`endif
            end
            RND:  state_next = OUT;
            OUT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge adc_clk) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                int_i_reg[k] <= '0;
                int_q_reg[k] <= '0;
                dly_i_reg[k] <= '0;
                dly_q_reg[k] <= '0;
            end
            comb_i_reg     <= '0;
            comb_q_reg     <= '0;
            dec_cnt_reg    <= '0;
            stage_reg      <= '0;
            out_strobe_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            out_i_reg      <= '0;
            out_q_reg      <= '0;
`ifdef CIC_ROUND_EN
            rnd_i_reg      <= '0;
            rnd_q_reg      <= '0;
`endif
        end else begin
            out_strobe_reg <= 1'b0;
            if (in_strobe) begin
                for (int k = 0; k < STAGES; k++) begin
                    int_i_reg[k] <= int_i_next[k];
                    int_q_reg[k] <= int_q_next[k];
                end
                dec_cnt_reg <= (dec_cnt_reg == CW'(DECIM - 1)) ? '0 : dec_cnt_reg + 1'b1;
            end
            // A decimation event while the comb section is busy is dropped.
            if (dec_event && state_reg != IDLE) overrun_reg <= 1'b1;
            case (state_reg)
                IDLE: if (dec_event) begin
                    comb_i_reg <= int_i_next[STAGES-1];
                    comb_q_reg <= int_q_next[STAGES-1];
                    stage_reg  <= '0;
                end
                COMB: begin
                    comb_i_reg           <= comb_i_reg - dly_i_reg[stage_reg];
                    comb_q_reg           <= comb_q_reg - dly_q_reg[stage_reg];
                    dly_i_reg[stage_reg] <= comb_i_reg;
                    dly_q_reg[stage_reg] <= comb_q_reg;
                    stage_reg            <= stage_reg + 1'b1;
                end
                RND: begin
`ifdef CIC_ROUND_EN
                    rnd_i_reg <= (rnd_i_wide[OUT_WIDTH] != rnd_i_wide[OUT_WIDTH-1]) ? OUT_MAX : rnd_i_wide[OUT_WIDTH-1:0];
                    rnd_q_reg <= (rnd_q_wide[OUT_WIDTH] != rnd_q_wide[OUT_WIDTH-1]) ? OUT_MAX : rnd_q_wide[OUT_WIDTH-1:0];
`endif
                end
                OUT: begin
`ifdef CIC_ROUND_EN
                    out_i_reg <= rnd_i_reg;
                    out_q_reg <= rnd_q_reg;
`else
                    out_i_reg <= comb_i_reg[ACCW-1 -: OUT_WIDTH];
                    out_q_reg <= comb_q_reg[ACCW-1 -: OUT_WIDTH];
`endif
                    out_strobe_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_strobe = out_strobe_reg;
    assign out_data_i = out_i_reg;
    assign out_data_q = out_q_reg;
    assign overrun    = overrun_reg;
endmodule

// File: tb/tb_cic_iq_decim.sv
// Scoreboard bench for cic_iq_decim: sample-level CIC reference model, expected outputs queued per decimation.
module tb_cic_iq_decim;
    localparam int IN_WIDTH  = 24;
    localparam int OUT_WIDTH = 24;
    localparam int STAGES    = 5;
    localparam int DECIM     = 3;
    localparam int GROWTH    = $clog2(DECIM ** STAGES);
    localparam int ACCW      = IN_WIDTH + GROWTH;
`ifdef CIC_ROUND_EN
    localparam int  LAT      = STAGES + 2;
    localparam longint EXP_I2 = 2;
    localparam longint EXP_QDC = -9492;
`else
    localparam int  LAT      = STAGES + 1;
    localparam longint EXP_I2 = 1;
    localparam longint EXP_QDC = -9493;
`endif

    logic adc_clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_strobe = 1'b0;
    logic signed [IN_WIDTH-1:0]  in_data_i = '0;
    logic signed [IN_WIDTH-1:0]  in_data_q = '0;
    logic                        out_strobe;
    logic signed [OUT_WIDTH-1:0] out_data_i;
    logic signed [OUT_WIDTH-1:0] out_data_q;
    logic                        overrun;

    always #5 adc_clk = ~adc_clk;

    cic_iq_decim #(
        .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .STAGES(STAGES), .DECIM(DECIM)
    ) dut (
        .adc_clk(adc_clk), .reset_n(reset_n), .in_strobe(in_strobe),
        .in_data_i(in_data_i), .in_data_q(in_data_q),
        .out_strobe(out_strobe), .out_data_i(out_data_i), .out_data_q(out_data_q),
        .overrun(overrun)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    int cyc = 0;
    always @(posedge adc_clk) cyc <= cyc + 1;

    typedef struct { longint i; longint q; longint cyc; } exp_t;
    exp_t exp_q[$];
    logic sb_en = 1'b0;

    logic signed [ACCW-1:0] m_int_i [STAGES];
    logic signed [ACCW-1:0] m_int_q [STAGES];
    logic signed [ACCW-1:0] m_dly_i [STAGES];
    logic signed [ACCW-1:0] m_dly_q [STAGES];
    int m_cnt = 0;

    function automatic longint scale(input logic signed [ACCW-1:0] x);
        longint v;
        v = longint'(x);
`ifdef CIC_ROUND_EN
        v = (v + (longint'(1) << (ACCW - OUT_WIDTH - 1))) >>> (ACCW - OUT_WIDTH);
        if (v > (longint'(1) << (OUT_WIDTH - 1)) - 1) v = (longint'(1) << (OUT_WIDTH - 1)) - 1;
`else
        v = v >>> (ACCW - OUT_WIDTH);
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < STAGES; k++) begin
            m_int_i[k] = '0; m_int_q[k] = '0; m_dly_i[k] = '0; m_dly_q[k] = '0;
        end
        m_cnt = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic signed [IN_WIDTH-1:0] di, input logic signed [IN_WIDTH-1:0] dq,
                              input int event_cyc);
        logic signed [ACCW-1:0] xi, xq, yi, yq;
        exp_t e;
        for (int k = STAGES - 1; k > 0; k--) begin
            m_int_i[k] = m_int_i[k] + m_int_i[k-1];
            m_int_q[k] = m_int_q[k] + m_int_q[k-1];
        end
        m_int_i[0] = m_int_i[0] + {{GROWTH{di[IN_WIDTH-1]}}, di};
        m_int_q[0] = m_int_q[0] + {{GROWTH{dq[IN_WIDTH-1]}}, dq};
        if (m_cnt == DECIM - 1) begin
            xi = m_int_i[STAGES-1];
            xq = m_int_q[STAGES-1];
            for (int k = 0; k < STAGES; k++) begin
                yi = xi - m_dly_i[k]; m_dly_i[k] = xi; xi = yi;
                yq = xq - m_dly_q[k]; m_dly_q[k] = xq; xq = yq;
            end
            e.i = scale(xi);
            e.q = scale(xq);
            e.cyc = event_cyc + LAT;
            exp_q.push_back(e);
        end
        m_cnt = (m_cnt + 1) % DECIM;
    endtask

    // Caller is at a negedge; the strobe is sampled on the next posedge.
    task automatic drive_strobe(input logic signed [IN_WIDTH-1:0] di, input logic signed [IN_WIDTH-1:0] dq,
                                input int gap);
        in_strobe = 1'b1;
        in_data_i = di;
        in_data_q = dq;
        if (sb_en) model_step(di, dq, cyc + 1);
        @(negedge adc_clk);
        in_strobe = 1'b0;
        repeat (gap - 1) @(negedge adc_clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge adc_clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    logic   prev_strobe = 1'b0;
    int     pulses = 0;
    longint last_i = 0;
    longint last_q = 0;

    always @(negedge adc_clk) begin
        if (out_strobe) begin
            exp_t e;
            pulses++;
            check_val("pulse_width", prev_strobe, 0);
            last_i = out_data_i;
            last_q = out_data_q;
            $display("out %0d: i=%0d q=%0d cyc=%0d", pulses, out_data_i, out_data_q, cyc);
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_strobe_qdepth", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_val("out_i", out_data_i, e.i);
                    check_val("out_q", out_data_q, e.q);
                    check_val("latency_cyc", cyc, e.cyc);
                end
            end
        end
        prev_strobe = out_strobe;
    end

    initial begin
        int p0;
        model_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge adc_clk);
        check_val("rst_strobe", out_strobe, 0);
        check_val("rst_i", out_data_i, 0);
        check_val("rst_q", out_data_q, 0);
        check_val("rst_overrun", overrun, 0);
        reset_n = 1'b1;
        sb_en = 1'b1;

        // Nine strobes give exactly three outputs
        for (int n = 0; n < 9; n++) drive_strobe(24'sd10000, -24'sd10000, 8);
        repeat (10) @(negedge adc_clk);
        check_val("nine_strobes_pulses", pulses, 3);
        check_val("nine_strobes_overrun", overrun, 0);
        check_val("nine_strobes_drain", exp_q.size(), 0);

        // DC steady state over 40 strobes
        for (int n = 0; n < 31; n++) drive_strobe(24'sd10000, -24'sd10000, 8);
        repeat (10) @(negedge adc_clk);
        check_val("dc_pulses", pulses, 13);
        check_val("dc_i", last_i, 9492);
        check_val("dc_q", last_q, EXP_QDC);
        check_val("dc_drain", exp_q.size(), 0);

        // Small DC on I, negative full scale on Q
        do_reset();
        for (int n = 0; n < 30; n++) drive_strobe(24'sd2, -24'sd8388608, 8);
        repeat (10) @(negedge adc_clk);
        check_val("dc2_i", last_i, EXP_I2);
        check_val("negfs_q", last_q, -7962624);
        check_val("negfs_drain", exp_q.size(), 0);

        // Random data at the tightest loss-free spacing
        for (int n = 0; n < 36; n++)
            drive_strobe(IN_WIDTH'($urandom), IN_WIDTH'($urandom), 3);
        repeat (12) @(negedge adc_clk);
        check_val("rand_overrun", overrun, 0);
        check_val("rand_drain", exp_q.size(), 0);

        // Strobe every cycle: second decimation event lands mid-comb
        sb_en = 1'b0;
        for (int n = 0; n < 5; n++) drive_strobe(24'sd5000, 24'sd5000, 1);
        check_val("ovr_after_first_event", overrun, 0);
        drive_strobe(24'sd5000, 24'sd5000, 1);
        check_val("ovr_after_second_event", overrun, 1);
        for (int n = 0; n < 12; n++) drive_strobe(24'sd5000, 24'sd5000, 1);
        repeat (20) @(negedge adc_clk);
        check_val("ovr_sticky", overrun, 1);

        // Reset while the comb section is busy
        drive_strobe(24'sd4000, 24'sd4000, 8);
        drive_strobe(24'sd4000, 24'sd4000, 8);
        drive_strobe(24'sd4000, 24'sd4000, 2);
        do_reset();
        check_val("midrst_strobe", out_strobe, 0);
        check_val("midrst_i", out_data_i, 0);
        check_val("midrst_q", out_data_q, 0);
        check_val("midrst_overrun", overrun, 0);
        sb_en = 1'b1;
        p0 = pulses;
        drive_strobe(24'sd7000, -24'sd3000, 8);
        drive_strobe(24'sd7000, -24'sd3000, 8);
        repeat (10) @(negedge adc_clk);
        check_val("postrst_no_early_out", pulses, p0);
        drive_strobe(24'sd7000, -24'sd3000, 8);
        repeat (10) @(negedge adc_clk);
        check_val("postrst_first_out", pulses, p0 + 1);
        check_val("postrst_drain", exp_q.size(), 0);
        check_val("postrst_overrun", overrun, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
